// File: rtl/bcd_display_pkg.sv
// Shared types and constants for the sequential binary-to-BCD display path.
package bcd_display_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } conv_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} codes for decimal digits
    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;

    // Smallest number of decimal digits able to hold 2**width-1
    function automatic int digits_needed(input int width);
        longint unsigned max_v;
        longint unsigned pow_v;
        int              d;
        max_v = (64'd1 << width) - 64'd1;
        pow_v = 64'd1;
        d     = 0;
        for (int i = 0; i < 20; i++) begin
            if (pow_v <= max_v) begin
                pow_v = pow_v * 64'd10;
                d     = d + 1;
            end else begin
                d     = d;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/dabble_add3.sv
// Double-dabble nibble correction: adds 3 to any BCD nibble of 5 or more.
module dabble_add3 (
    input  logic [3:0] nib_in,
    output logic [3:0] nib_out
);

    assign nib_out = (nib_in >= 4'd5) ? (nib_in + 4'd3) : nib_in;

endmodule

// File: rtl/seven_segment_driver.sv
// Single-digit BCD to active-low seven-segment decoder; non-decimal nibbles blank.
module seven_segment_driver
    import bcd_display_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    // Digit lookup
    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bin_to_bcd_seq_display.sv
// Iterative shift-and-add-3 binary-to-BCD converter driving DIGITS seven-segment displays.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits on the display only.
module bin_to_bcd_seq_display
    import bcd_display_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   seg
);

    localparam int BCD_W  = 4 * DIGITS;
    localparam int WORK_W = BCD_W + WIDTH;
    localparam int CNT_W  = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("bin_to_bcd_seq_display: WIDTH must be within 1..32");
    end
    if (DIGITS < digits_needed(WIDTH)) begin : g_bad_digits
        $error("bin_to_bcd_seq_display: DIGITS too small for WIDTH");
    end

    conv_state_t        state_r, state_nxt_s;
    logic [WORK_W-1:0]  work_r, work_nxt_s;
    logic [WORK_W-1:0]  adjusted_s, shifted_s;
    logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
    logic [BCD_W-1:0]   bcd_r, bcd_nxt_s;
    logic               busy_r, busy_nxt_s;
    logic               done_r, done_nxt_s;
    logic [DIGITS-1:0]  blank_s;

    // The binary part passes through untouched; each BCD nibble gets corrected before the shift
    assign adjusted_s[WIDTH-1:0] = work_r[WIDTH-1:0];
    for (genvar i = 0; i < DIGITS; i++) begin : g_dabble
        dabble_add3 u_add3 (
            .nib_in  (work_r[WIDTH+4*i +: 4]),
            .nib_out (adjusted_s[WIDTH+4*i +: 4])
        );
    end
    assign shifted_s = {adjusted_s[WORK_W-2:0], 1'b0};

    // Next-state and register-update logic
    always_comb begin
        state_nxt_s = state_r;
        work_nxt_s  = work_r;
        cnt_nxt_s   = cnt_r;
        bcd_nxt_s   = bcd_r;
        busy_nxt_s  = busy_r;
        done_nxt_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    work_nxt_s  = {{BCD_W{1'b0}}, bin};
                    cnt_nxt_s   = '0;
                    busy_nxt_s  = 1'b1;
                    state_nxt_s = SHIFT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SHIFT: begin
                work_nxt_s = shifted_s;
                cnt_nxt_s  = cnt_r + CNT_ONE;
                if (cnt_r == CNT_LAST) begin
                    bcd_nxt_s   = shifted_s[WORK_W-1 -: BCD_W];
                    done_nxt_s  = 1'b1;
                    busy_nxt_s  = 1'b0;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = SHIFT;
                end
            end
            default: begin
                busy_nxt_s  = 1'b0;
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            work_r  <= '0;
            cnt_r   <= '0;
            bcd_r   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            work_r  <= work_nxt_s;
            cnt_r   <= cnt_nxt_s;
            bcd_r   <= bcd_nxt_s;
            busy_r  <= busy_nxt_s;
            done_r  <= done_nxt_s;
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign bcd  = bcd_r;

`ifdef LEADING_ZERO_BLANK_EN
    logic nonzero_s;

    // A digit blanks when it and every more significant digit are zero; digit 0 always shows
    always_comb begin
        blank_s   = '0;
        nonzero_s = 1'b0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (bcd_r[4*i +: 4] != 4'd0) begin
                nonzero_s = 1'b1;
            end else begin
                nonzero_s = nonzero_s;
            end
            blank_s[i] = ~nonzero_s;
        end
    end
`else
    assign blank_s = '0;
`endif

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        logic [6:0] dec_s;
        seven_segment_driver u_drv (
            .digit (bcd_r[4*i +: 4]),
            .seg   (dec_s)
        );
        assign seg[7*i +: 7] = blank_s[i] ? SEG_BLANK : dec_s;
    end

endmodule

// File: tb/tb_bin_to_bcd_seq_display.sv
// Self-checking bench for bin_to_bcd_seq_display against a decimal-arithmetic reference model.
module tb_bin_to_bcd_seq_display;

    localparam int WIDTH  = 8;
    localparam int DIGITS = 3;

    logic                clk;
    logic                rst_n;
    logic                start;
    logic [WIDTH-1:0]    bin;
    logic                busy;
    logic                done;
    logic [4*DIGITS-1:0] bcd;
    logic [7*DIGITS-1:0] seg;

    int checks;
    int errors;
    logic [4*DIGITS-1:0] last_exp;

    localparam logic [6:0] SEG_TAB [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                            7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    bin_to_bcd_seq_display #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd),
        .seg   (seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pow10(input int n);
        int p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [4*DIGITS-1:0] ref_bcd(input int v);
        logic [4*DIGITS-1:0] r;
        r = '0;
        for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
        return r;
    endfunction

    function automatic logic [7*DIGITS-1:0] ref_seg(input int v);
        logic [7*DIGITS-1:0] r;
        for (int i = 0; i < DIGITS; i++) begin
            r[7*i +: 7] = SEG_TAB[(v / pow10(i)) % 10];
`ifdef LEADING_ZERO_BLANK_EN
            if (i > 0 && v < pow10(i)) r[7*i +: 7] = 7'h7F;
`endif
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full conversion from a start pulse, checking latency, handshake and result
    task automatic run_conv(input int v);
        int lat;
        @(negedge clk);
        bin   = WIDTH'(v);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_on_accept", 64'(busy), 64'd1);
        check("bcd_holds_prev", 64'(bcd), 64'(last_exp));
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 64'(lat), 64'(WIDTH));
        check("busy_low_at_done", 64'(busy), 64'd0);
        check("bcd", 64'(bcd), 64'(ref_bcd(v)));
        check("seg", 64'(seg), 64'(ref_seg(v)));
        last_exp = ref_bcd(v);
        @(posedge clk);
        #1;
        check("done_one_cycle", 64'(done), 64'd0);
    endtask

    initial begin
        int lat;
        int gap;
        int dones;
        int v;
        checks   = 0;
        errors   = 0;
        last_exp = '0;
        rst_n    = 1'b0;
        start    = 1'b0;
        bin      = '0;
        #1;
        check("reset_bcd", 64'(bcd), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_seg", 64'(seg), 64'(ref_seg(0)));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed boundaries
        run_conv(255);
        run_conv(0);
        run_conv(9);
        run_conv(10);
        run_conv(99);
        run_conv(100);
        run_conv(128);
        run_conv(1);

        // Randomized values
        for (int n = 0; n < 12; n++) begin
            v = int'($urandom_range(0, 255));
            run_conv(v);
        end

        // start held high: back-to-back, bin changed mid-conversion
        @(negedge clk);
        bin   = WIDTH'(100);
        start = 1'b1;
        @(negedge clk);
        bin   = WIDTH'(37);
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("b2b_first_bcd", 64'(bcd), 64'(ref_bcd(100)));
        gap = 0;
        @(posedge clk);
        #1;
        gap++;
        start = 1'b0;
        check("b2b_reaccept_busy", 64'(busy), 64'd1);
        while (done !== 1'b1 && gap < 40) begin
            @(posedge clk);
            #1;
            gap++;
        end
        check("b2b_spacing", 64'(gap), 64'(WIDTH + 1));
        check("b2b_second_bcd", 64'(bcd), 64'(ref_bcd(37)));
        last_exp = ref_bcd(37);

        // start pulsed while busy is ignored
        @(negedge clk);
        bin   = WIDTH'(200);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        bin   = WIDTH'(55);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        for (int c = 0; c < 3 * WIDTH; c++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) dones++;
        end
        check("ignore_done_count", 64'(dones), 64'd1);
        check("ignore_bcd", 64'(bcd), 64'(ref_bcd(200)));
        check("ignore_busy_idle", 64'(busy), 64'd0);
        last_exp = ref_bcd(200);

        // Reset mid-conversion after four shifts
        @(negedge clk);
        bin   = WIDTH'(77);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_bcd", 64'(bcd), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_seg", 64'(seg), 64'(ref_seg(0)));
        last_exp = '0;
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int c = 0; c < WIDTH + 2; c++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) dones++;
        end
        check("midrst_stays_idle", 64'(dones), 64'd0);
        run_conv(42);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
